// File: rtl/spi_reg_ctrl_pkg.sv
// Shared definitions for the SPI register controller of the tone generator:
// frame parser state encoding, command format and default register map size.
package spi_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  localparam int CMD_WRITE_BIT = 7;
  localparam int DEF_NUM_REGS  = 16;
  localparam int DEF_ADDR_W    = 4;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-stream and register-bank signals between the SPI byte receiver side
// (master) and the frame parser / register controller (slave).
interface spi_reg_ctrl_if
  import spi_reg_ctrl_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS
) ();

  logic [7:0]            rx_data_in;
  logic                  rx_valid_in;
  logic                  trans_valid_in;
  logic [NUM_REGS*8-1:0] regs_out;
  logic                  commit_out;
  logic                  err_out;
  logic                  busy_out;

  modport master (
    output rx_data_in, rx_valid_in, trans_valid_in,
    input  regs_out, commit_out, err_out, busy_out
  );

  modport slave (
    input  rx_data_in, rx_valid_in, trans_valid_in,
    output regs_out, commit_out, err_out, busy_out
  );

endinterface

// File: rtl/spi_reg_bank.sv
// Shadow/active register storage: bytes land in the shadow bank and the whole
// bank is copied to the active bank in one clock on commit.
module spi_reg_bank
  import spi_reg_ctrl_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [7:0]            wdata,
  input  logic                  commit,
  output logic [NUM_REGS*8-1:0] regs
);

  logic [7:0]            shadow_r [NUM_REGS];
  logic [NUM_REGS*8-1:0] active_r;

  // Shadow write port and atomic commit; a byte written in the commit cycle is
  // forwarded so it is part of the committed image.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= 8'h00;
      end
      active_r <= {(NUM_REGS*8){1'b0}};
    end else begin
      if (we) begin
        shadow_r[addr] <= wdata;
      end
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          active_r[i*8 +: 8] <= (we && (addr == ADDR_W'(i))) ? wdata : shadow_r[i];
        end
      end
    end
  end

  assign regs = active_r;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frame parser: a chip-select frame is a command byte followed by data bytes
// written to auto-incrementing shadow addresses, committed at frame end.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input logic           clk_in,
  input logic           reset_n_in,
  spi_reg_ctrl_if.slave bus
);

  state_e              state_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic                dirty_r;
  logic                trans_prev_r;
  logic                err_r;
  logic                commit_r;
  logic                busy_r;
  logic                rise_s;
  logic                fall_s;
  logic                write_s;
  logic                commit_s;
  logic                unused_cmd_bits_s;

  // trans_prev_r resets high so a frame already running at reset release is
  // not mistaken for a fresh one.
  assign rise_s   = bus.trans_valid_in & ~trans_prev_r;
  assign fall_s   = ~bus.trans_valid_in & trans_prev_r;
  assign write_s  = (state_r == ST_DATA) && bus.rx_valid_in;
  assign commit_s = fall_s && (state_r != ST_IDLE) && (dirty_r || write_s);
  assign unused_cmd_bits_s = ^bus.rx_data_in;

  // Frame FSM with pointer, dirty tracking and registered status pulses.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_r      <= ST_IDLE;
      ptr_r        <= {ADDR_W{1'b0}};
      dirty_r      <= 1'b0;
      trans_prev_r <= 1'b1;
      err_r        <= 1'b0;
      commit_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      trans_prev_r <= bus.trans_valid_in;
      err_r        <= 1'b0;
      commit_r     <= commit_s;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_r <= ST_CMD;
            busy_r  <= 1'b1;
          end
        end
        ST_CMD: begin
          if (bus.rx_valid_in) begin
            if (bus.rx_data_in[CMD_WRITE_BIT]) begin
              ptr_r   <= bus.rx_data_in[ADDR_W-1:0];
              state_r <= ST_DATA;
            end else begin
              err_r   <= 1'b1;
              state_r <= ST_DISCARD;
            end
          end
        end
        ST_DATA: begin
          if (bus.rx_valid_in) begin
            ptr_r   <= ptr_r + ADDR_W'(1);
            dirty_r <= 1'b1;
          end
        end
        ST_DISCARD: begin
          state_r <= ST_DISCARD;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      // Frame end overrides the per-state update after the byte was consumed.
      if (fall_s && (state_r != ST_IDLE)) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end
      if (commit_s) begin
        dirty_r <= 1'b0;
      end
    end
  end

  spi_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .we         (write_s),
    .addr       (ptr_r),
    .wdata      (bus.rx_data_in),
    .commit     (commit_s),
    .regs       (bus.regs_out)
  );

  assign bus.commit_out = commit_r;
  assign bus.err_out    = err_r;
  assign bus.busy_out   = busy_r;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized frame stimulus for spi_reg_ctrl, checked against a frame-level
// model of the shadow/active register banks.
module tb_spi_reg_ctrl;

  localparam int NREGS = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   commit_cnt = 0;
  int   err_cnt = 0;
  int   overlap_cnt = 0;

  logic [7:0] m_shadow [NREGS];
  logic [7:0] m_active [NREGS];
  logic [7:0] fq [$];

  spi_reg_ctrl_if #(.NUM_REGS(NREGS)) bus ();

  spi_reg_ctrl #(.NUM_REGS(NREGS), .ADDR_W(4)) dut (
    .clk_in     (clk),
    .reset_n_in (reset_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor
  always @(negedge clk) begin
    if (bus.commit_out) commit_cnt++;
    if (bus.err_out) err_cnt++;
    if (bus.commit_out && bus.err_out) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_regs();
    logic [127:0] v;
    for (int i = 0; i < NREGS; i++) v[i*8 +: 8] = m_active[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    bus.rx_data_in  = b;
    bus.rx_valid_in = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid_in = 1'b0;
  endtask

  // One frame: command byte then data; sim_last ends the frame on the last strobe.
  task automatic run_frame(input logic [7:0] frame [$], input bit sim_last);
    bit exp_err;
    bit wrote;
    int p;
    exp_err = !frame[0][7];
    wrote = 1'b0;
    if (!exp_err) begin
      p = int'(frame[0][3:0]);
      for (int i = 1; i < frame.size(); i++) begin
        m_shadow[p] = frame[i];
        p = (p + 1) % NREGS;
        wrote = 1'b1;
      end
      if (wrote) begin
        for (int i = 0; i < NREGS; i++) m_active[i] = m_shadow[i];
      end
    end
    @(posedge clk); #1;
    commit_cnt = 0;
    err_cnt = 0;
    bus.trans_valid_in = 1'b1;
    for (int i = 0; i < frame.size(); i++) begin
      if (sim_last && (i == frame.size() - 1)) begin
        @(posedge clk); #1;
        bus.rx_data_in     = frame[i];
        bus.rx_valid_in    = 1'b1;
        bus.trans_valid_in = 1'b0;
        @(posedge clk); #1;
        bus.rx_valid_in = 1'b0;
      end else begin
        send_byte(frame[i]);
      end
      if (i == 0) begin
        @(negedge clk);
        chk("err_pulse", 128'(bus.err_out), 128'(exp_err));
        chk("busy_in_frame", 128'(bus.busy_out), 128'(1'b1));
      end
    end
    if (!sim_last) begin
      @(posedge clk); #1;
      bus.trans_valid_in = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    chk("commit_latency", 128'(bus.commit_out), 128'(wrote));
    chk("regs_after_frame", bus.regs_out, exp_regs());
    @(negedge clk);
    chk("commit_one_cycle", 128'(bus.commit_out), 128'(1'b0));
    chk("busy_after_frame", 128'(bus.busy_out), 128'(1'b0));
    repeat (3) @(negedge clk);
    chk("commit_count", 128'(commit_cnt), 128'(wrote));
    chk("err_count", 128'(err_cnt), 128'(exp_err));
  endtask

  initial begin
    logic [7:0] cmd;
    int len;
    bit sl;
    bus.rx_data_in     = 8'h00;
    bus.rx_valid_in    = 1'b0;
    bus.trans_valid_in = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_regs", bus.regs_out, 128'h0);
    chk("reset_commit", 128'(bus.commit_out), 128'h0);
    chk("reset_err", 128'(bus.err_out), 128'h0);
    chk("reset_busy", 128'(bus.busy_out), 128'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    fq = {8'h82, 8'h11, 8'h22};
    run_frame(fq, 1'b0);
    chk("t1_reg2", 128'(bus.regs_out[23:16]), 128'(8'h11));
    chk("t1_reg3", 128'(bus.regs_out[31:24]), 128'(8'h22));
    fq = {8'h8F, 8'hAA, 8'hBB};
    run_frame(fq, 1'b0);
    chk("t2_reg15", 128'(bus.regs_out[127:120]), 128'(8'hAA));
    chk("t2_reg0", 128'(bus.regs_out[7:0]), 128'(8'hBB));
    fq = {8'h05, 8'h77};
    run_frame(fq, 1'b0);
    fq = {8'h84};
    run_frame(fq, 1'b0);
    fq = {8'h80, 8'h5A};
    run_frame(fq, 1'b1);
    chk("t5_reg0", 128'(bus.regs_out[7:0]), 128'(8'h5A));

    // Stray bytes outside a frame
    commit_cnt = 0;
    err_cnt = 0;
    send_byte(8'h83);
    send_byte(8'h9A);
    repeat (3) @(negedge clk);
    chk("stray_regs", bus.regs_out, exp_regs());
    chk("stray_busy", 128'(bus.busy_out), 128'h0);
    chk("stray_pulses", 128'(commit_cnt + err_cnt), 128'h0);

    // Reset in the middle of a frame, frame continues afterwards
    @(posedge clk); #1;
    bus.trans_valid_in = 1'b1;
    send_byte(8'h81);
    send_byte(8'h33);
    @(posedge clk); #1;
    reset_n = 1'b0;
    model_clear();
    #2;
    chk("midreset_regs", bus.regs_out, 128'h0);
    chk("midreset_busy", 128'(bus.busy_out), 128'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    commit_cnt = 0;
    err_cnt = 0;
    send_byte(8'h82);
    send_byte(8'h44);
    send_byte(8'h55);
    @(negedge clk);
    chk("postreset_busy", 128'(bus.busy_out), 128'h0);
    @(posedge clk); #1;
    bus.trans_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("postreset_no_commit", 128'(commit_cnt), 128'h0);
    chk("postreset_regs", bus.regs_out, 128'h0);
    fq = {8'h81, 8'h66};
    run_frame(fq, 1'b0);

    for (int f = 0; f < 30; f++) begin
      cmd = 8'($urandom);
      cmd[7] = ($urandom_range(0, 4) != 0);
      len = $urandom_range(0, 20);
      fq = {cmd};
      for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
      sl = (len > 0) && ($urandom_range(0, 3) == 0);
      run_frame(fq, sl);
    end

    chk("no_commit_err_overlap", 128'(overlap_cnt), 128'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
